// File: rtl/nco_multi.sv
// nco_multi: multi-channel numerically controlled oscillator.
//
// Each channel has a phase accumulator, a phase offset, a waveform mode and a
// duty threshold. Software writes a staged copy of each register; a single
// commit pulse moves every channel's staged set into the active set in the
// same cycle, so multi-register updates take effect atomically.
//
// All channels share clk, en and sync, which keeps their outputs
// phase-coherent.
//
// Pipeline
//   edge k   : accumulators update (or clear on sync), carry captured
//   edge k+1 : offset added, waveform shaped, wave_out/wrap/out_valid loaded
//
// Optional build macro NCO_DITHER_EN
//   Adds a shared 16-bit LFSR whose low bits are added to the phase before it
//   is truncated to OUT_W bits. Without the macro the output is fully
//   deterministic.

module nco_multi #(
    parameter int NUM_CH = 3,
    parameter int ACC_W  = 16,
    parameter int OUT_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      sync,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [1:0]                cfg_addr,
    input  logic [ACC_W-1:0]          cfg_wdata,
    input  logic                      commit,
    output logic [NUM_CH*OUT_W-1:0]   wave_out,
    output logic [NUM_CH-1:0]         wrap,
    output logic                      out_valid
);

    typedef enum logic [1:0] {
        MODE_SAW    = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    // Duty resets to half scale so a freshly selected square wave is 50 %.
    localparam logic [ACC_W-1:0] DUTY_RST = {1'b1, {(ACC_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Register file: staged and active copies
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] stg_inc_q  [NUM_CH];
    logic [ACC_W-1:0] stg_off_q  [NUM_CH];
    mode_e            stg_mode_q [NUM_CH];
    logic [ACC_W-1:0] stg_duty_q [NUM_CH];
    logic [ACC_W-1:0] stg_inc_d  [NUM_CH];
    logic [ACC_W-1:0] stg_off_d  [NUM_CH];
    mode_e            stg_mode_d [NUM_CH];
    logic [ACC_W-1:0] stg_duty_d [NUM_CH];

    logic [ACC_W-1:0] act_inc_q  [NUM_CH];
    logic [ACC_W-1:0] act_off_q  [NUM_CH];
    mode_e            act_mode_q [NUM_CH];
    logic [ACC_W-1:0] act_duty_q [NUM_CH];
    logic [ACC_W-1:0] act_inc_d  [NUM_CH];
    logic [ACC_W-1:0] act_off_d  [NUM_CH];
    mode_e            act_mode_d [NUM_CH];
    logic [ACC_W-1:0] act_duty_d [NUM_CH];

    // Writes aimed at a channel number beyond NUM_CH-1 are dropped.
    logic cfg_hit;
    assign cfg_hit = cfg_we && (int'(cfg_ch) < NUM_CH);

    // Staged write decode, then commit copies staged into active. Because the
    // active copy samples the staged *register*, a write in the commit cycle
    // lands in staged only and waits for the next commit.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
            stg_inc_d[i]  = stg_inc_q[i];
            stg_off_d[i]  = stg_off_q[i];
            stg_mode_d[i] = stg_mode_q[i];
            stg_duty_d[i] = stg_duty_q[i];
            if (cfg_hit && (int'(cfg_ch) == i)) begin
                case (cfg_addr)
                    2'd0:    stg_inc_d[i]  = cfg_wdata;
                    2'd1:    stg_off_d[i]  = cfg_wdata;
                    2'd2:    stg_mode_d[i] = mode_e'(cfg_wdata[1:0]);
                    default: stg_duty_d[i] = cfg_wdata;
                endcase
            end

            act_inc_d[i]  = act_inc_q[i];
            act_off_d[i]  = act_off_q[i];
            act_mode_d[i] = act_mode_q[i];
            act_duty_d[i] = act_duty_q[i];
            if (commit) begin
                act_inc_d[i]  = stg_inc_q[i];
                act_off_d[i]  = stg_off_q[i];
                act_mode_d[i] = stg_mode_q[i];
                act_duty_d[i] = stg_duty_q[i];
            end
        end
    end

    // Staged and active register banks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: these small per-channel arrays are real flops, not RAM, so every entry is reset explicitly.
            for (int i = 0; i < NUM_CH; i++) begin
                stg_inc_q[i]  <= '0;
                stg_off_q[i]  <= '0;
                stg_mode_q[i] <= MODE_SAW;
                stg_duty_q[i] <= DUTY_RST;
                act_inc_q[i]  <= '0;
                act_off_q[i]  <= '0;
                act_mode_q[i] <= MODE_SAW;
                act_duty_q[i] <= DUTY_RST;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            for (int i = 0; i < NUM_CH; i++) begin
                stg_inc_q[i]  <= stg_inc_d[i];
                stg_off_q[i]  <= stg_off_d[i];
                stg_mode_q[i] <= stg_mode_d[i];
                stg_duty_q[i] <= stg_duty_d[i];
                act_inc_q[i]  <= act_inc_d[i];
                act_off_q[i]  <= act_off_d[i];
                act_mode_q[i] <= act_mode_d[i];
                act_duty_q[i] <= act_duty_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: phase accumulators
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]  acc_q   [NUM_CH];
    logic [ACC_W-1:0]  acc_d   [NUM_CH];
    logic [NUM_CH-1:0] carry_q;
    logic [NUM_CH-1:0] carry_d;
    logic              v1_q;
    logic              v1_d;

    // Accumulate with carry out. sync outranks en, and an "off" channel is
    // parked at zero so it restarts cleanly when re-enabled.
    always_comb begin
        logic [ACC_W:0] sum;
        sum     = '0;
        carry_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
            sum      = {1'b0, acc_q[i]} + {1'b0, act_inc_q[i]};
            if (sync || (act_mode_q[i] == MODE_OFF)) begin
                acc_d[i] = '0;
            end else if (en) begin
                acc_d[i]   = sum[ACC_W-1:0];
                carry_d[i] = sum[ACC_W];
            end
        end
        v1_d = en | sync;
    end

    // Accumulator, carry and stage-1 valid registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
            carry_q <= '0;
            v1_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
            end
            carry_q <= carry_d;
            v1_q    <= v1_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional phase dither source
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] dith;

`ifdef NCO_DITHER_EN
    localparam int DITH_W = ACC_W - OUT_W;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advanced on every en cycle; its
    // low DITH_W bits are shared by all channels.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        dith = '0;
        for (int b = 0; (b < DITH_W) && (b < 16); b++) begin
            dith[b] = lfsr_q[b];
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // Deterministic build: no dither is added to the phase.
    assign dith = '0;
`endif

    // ------------------------------------------------------------------
    // Stage 2: offset, waveform shaping, output registers
    // ------------------------------------------------------------------
    logic [OUT_W-1:0]  wave_q [NUM_CH];
    logic [OUT_W-1:0]  wave_d [NUM_CH];
    logic [NUM_CH-1:0] wrap_q;
    logic              valid_q;

    // Shape each channel's phase. The output only advances when stage 1
    // carried a new accumulator value, so idle cycles hold the last sample.
    always_comb begin
        logic [ACC_W-1:0] ph;
        logic [ACC_W-1:0] phd;
        logic [OUT_W-1:0] p;
        logic [OUT_W-1:0] tri_t;
        logic [OUT_W-1:0] w;
        ph    = '0;
        phd   = '0;
        p     = '0;
        tri_t = '0;
        w     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ph    = acc_q[i] + act_off_q[i];
            phd   = ph + dith;
            p     = phd[ACC_W-1 -: OUT_W];
            tri_t = {p[OUT_W-2:0], 1'b0};
            case (act_mode_q[i])
                MODE_SAW:    w = p;
                // Full-width unsigned compare; duty of 0 never matches.
                MODE_SQUARE: w = (ph < act_duty_q[i]) ? '1 : '0;
                MODE_TRI:    w = p[OUT_W-1] ? ~tri_t : tri_t;
                default:     w = '0;
            endcase
            wave_d[i] = v1_q ? w : wave_q[i];
        end
    end

    // Output sample, wrap pulse and valid registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wave_q[i] <= '0;
            end
            wrap_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                wave_q[i] <= wave_d[i];
            end
            wrap_q  <= carry_q;
            valid_q <= v1_q;
        end
    end

    // Pack per-channel samples onto the flat output bus.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign wave_out[g*OUT_W +: OUT_W] = wave_q[g];
    end

    assign wrap      = wrap_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_nco_multi.sv
// Directed testbench for nco_multi with default parameters (3 channels,
// 16-bit accumulators, 8-bit samples), built without NCO_DITHER_EN.

module tb_nco_multi;

    logic        clk;
    logic        reset;
    logic        en;
    logic        sync;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        commit;
    logic [23:0] wave_out;
    logic [2:0]  wrap;
    logic        out_valid;

    int n_vec;
    int n_err;

    // Triangle samples for phase 0x0000, 0x4000, 0x8000, 0xC000.
    logic [7:0] tri_tab [4];

    nco_multi dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sync      (sync),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .commit    (commit),
        .wave_out  (wave_out),
        .wrap      (wrap),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] addr, input logic [15:0] data);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    function automatic logic [7:0] wv(input int ch);
        return wave_out[ch*8 +: 8];
    endfunction

    initial begin
        logic [15:0] a;
        logic [2:0]  wexp;
        n_vec = 0;
        n_err = 0;
        tri_tab[0] = 8'h00;
        tri_tab[1] = 8'h80;
        tri_tab[2] = 8'hFF;
        tri_tab[3] = 8'h7F;

        reset = 1'b0; en = 1'b0; sync = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0; commit = 1'b0;

        // Reset held while every input toggles: outputs stay zero.
        for (int k = 0; k < 4; k++) begin
            en        = k[0];
            sync      = ~k[0];
            cfg_we    = 1'b1;
            cfg_ch    = k[1:0];
            cfg_addr  = k[1:0];
            cfg_wdata = 16'hFFFF;
            commit    = 1'b1;
            tick();
            check("rst_wave", wave_out, 0);
            check("rst_wrap", wrap, 0);
            check("rst_valid", out_valid, 0);
        end
        en = 1'b0; sync = 1'b0; cfg_we = 1'b0; commit = 1'b0;
        cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("post_rst_wave", wave_out, 0);
        check("post_rst_wrap", wrap, 0);
        check("post_rst_valid", out_valid, 0);

        // Saw on ch0, phase_inc=2000: 0x07, 0x0F, 0x17, ..., 33rd = 0x01 with wrap.
        cfg_write(2'd0, 2'd0, 16'd2000);
        do_commit();
        en = 1'b1;
        tick();
        for (int n = 1; n <= 33; n++) begin
            tick();
            a = 16'((n * 2000) % 65536);
            check("saw_wave", wv(0), a[15:8]);
            check("saw_wrap0", wrap[0], (n == 33));
            check("saw_valid", out_valid, 1);
        end
        check("saw_ch1_idle", wv(1), 0);

        // en gap: one last sample (acc 68000 mod 2^16 = 2464 -> 0x09), then hold.
        en = 1'b0;
        tick();
        check("gap_last", wv(0), 8'h09);
        check("gap_last_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("gap_hold", wv(0), 8'h09);
            check("gap_valid", out_valid, 0);
            check("gap_wrap", wrap, 0);
        end
        en = 1'b1;
        tick();
        tick();
        check("gap_resume", wv(0), 8'h11);
        check("gap_resume_valid", out_valid, 1);

        // ch1 square (duty 0x4000, inc 0x1000), ch2 triangle (inc 0x4000).
        en = 1'b0;
        tick();
        cfg_write(2'd1, 2'd2, 16'd1);
        cfg_write(2'd1, 2'd3, 16'h4000);
        cfg_write(2'd1, 2'd0, 16'h1000);
        cfg_write(2'd2, 2'd2, 16'd2);
        cfg_write(2'd2, 2'd0, 16'h4000);
        do_commit();
        sync = 1'b1;
        en   = 1'b1;
        tick();
        sync = 1'b0;
        // Sample j shows accumulator value (j-1)*inc.
        for (int j = 1; j <= 20; j++) begin
            tick();
            a = 16'(((j - 1) * 2000) % 65536);
            check("run_saw", wv(0), a[15:8]);
            a = 16'(((j - 1) * 32'h1000) % 65536);
            check("run_square", wv(1), (a < 16'h4000) ? 8'hFF : 8'h00);
            check("run_tri", wv(2), tri_tab[(j - 1) % 4]);
            wexp    = '0;
            wexp[1] = (j > 1) && (((j - 1) % 16) == 0);
            wexp[2] = (j > 1) && (((j - 1) % 4) == 0);
            check("run_wrap", wrap, wexp);
        end

        // Triangle with phase_off=0x4000: sequence shifts by one sample.
        en = 1'b0;
        tick();
        cfg_write(2'd2, 2'd1, 16'h4000);
        do_commit();
        sync = 1'b1;
        en   = 1'b1;
        tick();
        sync = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("tri_offset", wv(2), tri_tab[j % 4]);
        end

        // Staging: ch0 inc write without commit has no effect; commit applies it
        // to the following update; a write in the commit cycle stays staged.
        en   = 1'b0;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        cfg_write(2'd0, 2'd0, 16'h0100);
        en = 1'b1;
        tick();
        tick();
        check("stage_nocommit", wv(0), 8'h07);
        commit    = 1'b1;
        cfg_we    = 1'b1;
        cfg_ch    = 2'd0;
        cfg_addr  = 2'd0;
        cfg_wdata = 16'h0200;
        tick();
        commit = 1'b0;
        cfg_we = 1'b0;
        check("stage_commit_cycle", wv(0), 8'h0F);
        tick();
        check("stage_old_inc", wv(0), 8'h17);
        tick();
        check("stage_new_inc", wv(0), 8'h18);
        tick();
        check("stage_not_leaked", wv(0), 8'h19);

        // sync together with en: every accumulator restarts from zero, no wrap.
        sync = 1'b1;
        tick();
        sync = 1'b0;
        en   = 1'b0;
        tick();
        check("sync_saw", wv(0), 8'h00);
        check("sync_square", wv(1), 8'hFF);
        check("sync_tri", wv(2), 8'h80);
        check("sync_wrap", wrap, 0);
        check("sync_valid", out_valid, 1);

        // Reset pulse mid-run: outputs clear at once and config reverts.
        en = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_wave", wave_out, 0);
        check("midrst_wrap", wrap, 0);
        check("midrst_valid", out_valid, 0);
        #2;
        en    = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("midrst_idle_wave", wave_out, 0);
        check("midrst_idle_valid", out_valid, 0);
        en = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("midrst_default_wave", wave_out, 0);
        check("midrst_default_wrap", wrap, 0);
        check("midrst_default_valid", out_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
